fft4_psd_avg: RTL
=================

# fft4_psd_avg

Downstream consumer of the 4-point streaming FFT. It takes frames of four complex bins on an AXI-Stream slave, computes per-bin power re²+im², and averages it over 2^AVG_LOG2 consecutive frames. It then emits the four averaged power values as one AXI-Stream frame, closing the spectrum-estimation path of the FFT processor.

## Interface
- AVG_LOG2, default 2: log2 of frames averaged per output frame; legal 0..8.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_axis_tdata  in  32  FFT bin: [31:16] signed real, [15:0] signed imaginary.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  block accepts input.
- s_axis_tlast  in  1  last bin of FFT frame.
- m_axis_tdata  out  32  unsigned averaged power of one bin.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts output.
- m_axis_tlast  out  1  high on bin 3 of output frame.
- err_frame  out  1  sticky framing error (see Configuration).

## Operation
- States: ACCUM, FLUSH, DRAIN.
- ACCUM: s_axis_tready=1. Each handshake squares re and im (signed 16×16 → 32), sums to 32-bit unsigned power p. Max p = 2^31 at (-32768,-32768), no overflow.
- p is registered one stage, then added into acc[bin]. acc[0..3] are each 32+AVG_LOG2 bits wide and cannot overflow.
- bin counter is 2 bits, wraps 3→0. frame counter is AVG_LOG2 bits wide.
- Handshake with bin==3 and frame==2^AVG_LOG2-1: go to FLUSH. Otherwise bin==3 increments the frame counter.
- FLUSH: one cycle. The last product lands in acc[3]. s_axis_tready=0.
- DRAIN: s_axis_tready=0. out counter k runs 0..3.
  - m_axis_tdata = acc[k] >> AVG_LOG2 (truncate).
  - m_axis_tlast = (k==3).
  - On handshake, acc[k] is cleared and k increments.
  - Handshake with k==3: go to ACCUM, with bin and frame counters at 0.
- AVG_LOG2=0: every input frame yields one output frame, power passed unscaled.
- Reset, asserted at any time including mid-DRAIN: state=ACCUM, all counters and acc cleared, pipeline register invalid, partial frames discarded.
- Output reset values: s_axis_tready=0 while rst_n low, 1 from first edge after release. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, err_frame=0.

## Timing
- Input throughput: 1 beat/cycle in ACCUM.
- Final input beat accepted at edge E:
  - FLUSH in cycle E..E+1.
  - m_axis_tvalid high from edge E+1 (registered).
  - s_axis_tready low from edge E.
- Output: up to 1 beat/cycle. With m_axis_tready held high, 4 beats on consecutive cycles.
- AXI rules: m_axis_tdata/tlast hold stable while tvalid && !tready. tvalid never drops without a handshake.
- s_axis_tready returns high on the edge after the k==3 output handshake.
- Per-frame dead time: 1 FLUSH cycle + 4 DRAIN cycles minimum. Upstream stalls via tready.
- s_axis_tdata is ignored when tvalid=0 or tready=0.

## Configuration
- FFT4_PSD_FRAMECHK_EN defined: s_axis_tlast is checked on every accepted beat. A mismatch (tlast=1 with bin!=3, or tlast=0 with bin==3) sets err_frame. err_frame is sticky until reset.
  - Early tlast: the beat is accumulated, then bin is forced to 0. The frame counter does not advance.
  - Missing tlast: the frame is still counted normally.
- FFT4_PSD_FRAMECHK_EN undefined: s_axis_tlast is ignored, bin wraps purely by count, err_frame is tied 0.

## Structure
- Shared package fft4_pkg:
  - sample-field widths (IN_W=16, PWR_W=32);
  - bin count constant N_BINS=4;
  - state enum typedef (ACCUM/FLUSH/DRAIN).
- One sub-module: fft4_cplx_pwr. It is a registered complex magnitude-squared unit: 1-cycle latency, valid in/out, bin tag passed through.

## Test plan
- AVG_LOG2=0. Frame (100,0), (-20,20), (-20,0), (-20,-20), tlast on 4th → outputs 10000, 800, 400, 800, tlast on 4th only.
- AVG_LOG2=2. Same frame sent 4 times back-to-back; s_axis_tready low after the 16th beat → outputs 10000, 800, 400, 800. Then a 5th input frame with all bins (1,1) → next output 2,2,2,2 after 4 frames... (send 4 such frames) → 2,2,2,2.
- AVG_LOG2=0. Bin (-32768,-32768) → output 0x80000000. Bin (0,0) → 0.
- m_axis_tready toggling 1,0,0,1 during DRAIN → data/last stable while stalled, exactly 4 beats, acc cleared afterward. Verified by a second frame of zeros yielding 0,0,0,0.
- rst_n pulsed low mid-DRAIN after 2 output beats → m_axis_tvalid=0 immediately. The next full frame gives correct fresh averages with no residue.
- FFT4_PSD_FRAMECHK_EN defined. tlast on beat 2 → err_frame=1 and remains 1. The following well-formed frame is aligned to bin 0.

Source files
------------

// File: rtl/fft4_pkg.sv
// Shared definitions for the 4-point FFT spectrum path: sample widths,
// bin count and the PSD averager state encoding.
package fft4_pkg;

  localparam int IN_W   = 16;  // signed real / imaginary field width
  localparam int PWR_W  = 32;  // unsigned power width (re^2 + im^2)
  localparam int N_BINS = 4;   // bins per FFT frame
  localparam int BIN_W  = 2;   // bin index width

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : fft4_pkg

// File: rtl/fft4_cplx_pwr.sv
// Registered complex magnitude-squared unit: pwr = re^2 + im^2, one cycle
// of latency, with the valid flag and bin tag travelling alongside.
module fft4_cplx_pwr
  import fft4_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  re,
  input  logic signed [IN_W-1:0]  im,
  input  logic [BIN_W-1:0]        in_bin,
  output logic                    out_valid,
  output logic [PWR_W-1:0]        pwr,
  output logic [BIN_W-1:0]        out_bin
);

  logic signed [2*IN_W-1:0] re_sq;
  logic signed [2*IN_W-1:0] im_sq;
  logic [PWR_W-1:0]         pwr_d;

  // Each square is at most 2^30, so the unsigned sum peaks at 2^31 and
  // never wraps in 32 bits.
  assign re_sq = re * re;
  assign im_sq = im * im;
  assign pwr_d = PWR_W'($unsigned(re_sq)) + PWR_W'($unsigned(im_sq));

  // Pipeline register: capture power and bin tag for every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pwr       <= '0;
      out_bin   <= '0;
    end else begin
      // NOTE: clocked state is always updated with non-blocking assignments
      // so every flop samples the pre-edge values regardless of statement order.
      out_valid <= in_valid;
      if (in_valid) begin
        pwr     <= pwr_d;
        out_bin <= in_bin;
      end
    end
  end

endmodule : fft4_cplx_pwr

// File: rtl/fft4_psd_avg.sv
// Power spectral density averager for the 4-point FFT. Squares each incoming
// bin, accumulates 2^AVG_LOG2 frames per bin, then streams the four averages
// out as one AXI-Stream frame.
// Optional feature: define FFT4_PSD_FRAMECHK_EN to check s_axis_tlast
// against the bin counter and flag mismatches on the sticky err_frame.
module fft4_psd_avg
  import fft4_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [PWR_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              err_frame
);

  localparam int ACC_W  = PWR_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_t             state_q, state_d;
  logic               rdy_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   frame_q;
  logic [BIN_W-1:0]   k_q;
  logic [ACC_W-1:0]   acc_q [N_BINS];

  logic               in_fire;
  logic               out_fire;
  logic               frame_done;
  logic               tlast_early;

  logic               p_valid;
  logic [PWR_W-1:0]   p_pwr;
  logic [BIN_W-1:0]   p_bin;

  // Input is only accepted in ACCUM, and never before the first edge after
  // reset release.
  assign s_axis_tready = rdy_q && (state_q == ACCUM);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign out_fire      = m_axis_tvalid && m_axis_tready;
  assign frame_done    = in_fire && (bin_q == BIN_W'(N_BINS - 1)) && (frame_q == FRAME_LAST);

`ifdef FFT4_PSD_FRAMECHK_EN
  logic err_q;
  logic tlast_bad;

  assign tlast_early = in_fire && s_axis_tlast && (bin_q != BIN_W'(N_BINS - 1));
  assign tlast_bad   = in_fire && (s_axis_tlast != (bin_q == BIN_W'(N_BINS - 1)));
  assign err_frame   = err_q;

  // Sticky framing error; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (tlast_bad) err_q <= 1'b1;
  end
`else
  logic unused_tlast;

  assign unused_tlast = s_axis_tlast;
  assign tlast_early  = 1'b0;
  assign err_frame    = 1'b0;
`endif

  fft4_cplx_pwr u_pwr (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_fire),
    .re        (s_axis_tdata[31:16]),
    .im        (s_axis_tdata[15:0]),
    .in_bin    (bin_q),
    .out_valid (p_valid),
    .pwr       (p_pwr),
    .out_bin   (p_bin)
  );

  // Ready enable: low through reset, high from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statement can infer a latch.
    state_d       = state_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    unique case (state_q)
      ACCUM: begin
        if (frame_done) state_d = FLUSH;
      end
      FLUSH: begin
        // The final product lands in acc[3] on this edge.
        state_d = DRAIN;
      end
      DRAIN: begin
        m_axis_tvalid = 1'b1;
        // Selecting bits [AVG_LOG2 +: 32] is the truncating divide by 2^AVG_LOG2.
        m_axis_tdata  = acc_q[k_q][AVG_LOG2 +: PWR_W];
        m_axis_tlast  = (k_q == BIN_W'(N_BINS - 1));
        if (m_axis_tready && (k_q == BIN_W'(N_BINS - 1))) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Bin, frame and output counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q   <= '0;
      frame_q <= '0;
      k_q     <= '0;
    end else begin
      if (in_fire) begin
        // An early tlast realigns the next beat to bin 0 without counting a frame.
        if (tlast_early) bin_q <= '0;
        else             bin_q <= bin_q + BIN_W'(1);
        if ((bin_q == BIN_W'(N_BINS - 1)) && !frame_done) frame_q <= frame_q + CNT_W'(1);
      end
      if (out_fire) begin
        k_q <= k_q + BIN_W'(1);
        if (k_q == BIN_W'(N_BINS - 1)) begin
          bin_q   <= '0;
          frame_q <= '0;
        end
      end
    end
  end

  // Per-bin accumulators: add registered power, clear each bin as it drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulators are a small register file, not RAM, and must
      // be reset so a reset mid-frame or mid-drain leaves no residue.
      for (int i = 0; i < N_BINS; i++) acc_q[i] <= '0;
    end else if (p_valid) begin
      acc_q[p_bin] <= acc_q[p_bin] + ACC_W'(p_pwr);
    end else if (out_fire) begin
      acc_q[k_q] <= '0;
    end
  end

endmodule : fft4_psd_avg
